perst_sequencer: RTL and testbench

PERST_SEQUENCER -- requirements
Module: perst_sequencer

---
 rtl/perst_sequencer.sv | 172 +++++++++++++++++
 tb/tb_perst_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perst_sequencer.sv
// perst_sequencer: staged PCIe PERST# release with optional link-up watchdog.
//
// Holds every channel in reset for HOLD_CYCLES after an accepted start, then
// releases channel i a further i*STAGGER_CYCLES later. Once the last channel
// is released it waits for all link_up bits. It then reports done, or, with
// the watchdog, timeout after TIMEOUT_CYCLES.
//
// Build option: define PERST_SEQ_WATCHDOG_EN to include the watchdog and the
// FAIL state. Without it, WAIT_LINK waits indefinitely and timeout/ch_timeout
// read 0.
//
// Ports:
//   clock       in   single clock
//   reset_n     in   synchronous active-low reset
//   start       in   sequence request (accepted in IDLE, DONE, FAIL)
//   link_up     in   [NUM_CH] per-channel link status
//   perst_n     out  [NUM_CH] per-channel PERST#, registered, active-low
//   busy        out  sequence in progress
//   done        out  all links up
//   timeout     out  watchdog expired
//   ch_timeout  out  [NUM_CH] channels whose link was down at expiry
module perst_sequencer #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned HOLD_CYCLES    = 500,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] link_up,
  output logic [NUM_CH-1:0] perst_n,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [NUM_CH-1:0] ch_timeout
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StHold    = 3'd1;
  localparam logic [2:0] StRelease = 3'd2;
  localparam logic [2:0] StWait    = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;
  localparam logic [2:0] StFail    = 3'd5;

  // Edge offset (from the accepting edge) at which the last channel releases.
  localparam int unsigned LastK = HOLD_CYCLES + (NUM_CH - 1) * STAGGER_CYCLES;
`ifdef PERST_SEQ_WATCHDOG_EN
  localparam int unsigned MaxCnt = (LastK > TIMEOUT_CYCLES) ? LastK : TIMEOUT_CYCLES;
`else
  localparam int unsigned MaxCnt = LastK;
`endif
  localparam int unsigned CntW = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] LastKC = CntW'(LastK);
  localparam logic [CntW-1:0] HoldC  = CntW'(HOLD_CYCLES);

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [NUM_CH-1:0] perst_q, perst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_ok;

`ifdef PERST_SEQ_WATCHDOG_EN
  localparam logic [CntW-1:0] TimeoutC = CntW'(TIMEOUT_CYCLES);
  logic              timeout_q, timeout_d;
  logic [NUM_CH-1:0] ch_to_q, ch_to_d;
`endif

  // cnt_inc is the edge offset of the edge being evaluated: in HOLD/RELEASE it
  // counts from the accepting edge, in WAIT_LINK from entry into WAIT_LINK.
  assign cnt_inc  = cnt_q + CntW'(1);
  assign start_ok = start && (state_q == StIdle || state_q == StDone || state_q == StFail);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perst_d = perst_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef PERST_SEQ_WATCHDOG_EN
    timeout_d = timeout_q;
    ch_to_d   = ch_to_q;
`endif
    if (start_ok) begin
      state_d = StHold;
      cnt_d   = '0;
      perst_d = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
`ifdef PERST_SEQ_WATCHDOG_EN
      timeout_d = 1'b0;
      ch_to_d   = '0;
`endif
    end else begin
      case (state_q)
        StHold, StRelease: begin
          cnt_d = cnt_inc;
          for (int i = 0; i < NUM_CH; i++) begin
            if (32'(cnt_inc) >= HOLD_CYCLES + 32'(i) * STAGGER_CYCLES) perst_d[i] = 1'b1;
          end
          // With one channel or no stagger the last release is also the first.
          if (cnt_inc == LastKC) begin
            state_d = StWait;
            cnt_d   = '0;
          end else if (cnt_inc == HoldC) begin
            state_d = StRelease;
          end
        end
        StWait: begin
          if (&link_up) begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
`ifdef PERST_SEQ_WATCHDOG_EN
          else begin
            cnt_d = cnt_inc;
            if (cnt_inc == TimeoutC) begin
              state_d   = StFail;
              timeout_d = 1'b1;
              busy_d    = 1'b0;
              ch_to_d   = ~link_up;
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      perst_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perst_q <= perst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PERST_SEQ_WATCHDOG_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
      ch_to_q   <= '0;
    end else begin
      timeout_q <= timeout_d;
      ch_to_q   <= ch_to_d;
    end
  end

  assign timeout    = timeout_q;
  assign ch_timeout = ch_to_q;
`else
  assign timeout    = 1'b0;
  assign ch_timeout = '0;
`endif

  assign perst_n = perst_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_perst_sequencer.sv
module tb_perst_sequencer;

  localparam int NCH = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [NCH-1:0] link_up = '0;
  logic [NCH-1:0] perst_n;
  logic           busy, done, timeout;
  logic [NCH-1:0] ch_timeout;

  int errors = 0;
  int checks = 0;
  int rel = 0;  // edges since the last accepted start

  perst_sequencer #(
    .NUM_CH(4),
    .HOLD_CYCLES(500),
    .STAGGER_CYCLES(16),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .link_up(link_up),
    .perst_n(perst_n),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .ch_timeout(ch_timeout)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    rel++;
  endtask

  task automatic run_to(input int target);
    while (rel < target) step();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    rel = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    step();
    step();
    start   = 1'b0;
    checks++;
    if ({perst_n, busy, done, timeout, ch_timeout} !== 12'h0) begin
      errors++;
      $display("FAIL reset_state: got perst_n=%h busy=%b done=%b timeout=%b ch_to=%h, want all 0",
               perst_n, busy, done, timeout, ch_timeout);
    end
    reset_n = 1'b1;
    step();
    step();
    checks++;
    if (perst_n !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got perst_n=%h busy=%b, want 0 0", perst_n, busy);
    end
  endtask

  task automatic test_sequence();
    link_up = 4'h0;
    do_start();
    checks++;
    if (perst_n !== 4'h0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_accept: got perst_n=%h busy=%b done=%b, want 0 1 0", perst_n, busy, done);
    end
    run_to(499);
    checks++;
    if (perst_n !== 4'h0) begin
      errors++;
      $display("FAIL hold_499: got perst_n=%h, want 0", perst_n);
    end
    run_to(500);
    checks++;
    if (perst_n !== 4'h1) begin
      errors++;
      $display("FAIL release_ch0: got perst_n=%h, want 1", perst_n);
    end
    run_to(516);
    checks++;
    if (perst_n !== 4'h3) begin
      errors++;
      $display("FAIL release_ch1: got perst_n=%h, want 3", perst_n);
    end
    run_to(547);
    checks++;
    if (perst_n !== 4'h7) begin
      errors++;
      $display("FAIL pre_ch3: got perst_n=%h, want 7", perst_n);
    end
    run_to(548);
    checks++;
    if (perst_n !== 4'hF || busy !== 1'b1) begin
      errors++;
      $display("FAIL release_ch3: got perst_n=%h busy=%b, want f 1", perst_n, busy);
    end
    run_to(589);
    link_up = 4'hF;
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL link_done: got done=%b busy=%b timeout=%b, want 1 0 0", done, busy, timeout);
    end
    link_up = 4'h0;
    step();
    step();
    checks++;
    if (done !== 1'b1 || perst_n !== 4'hF) begin
      errors++;
      $display("FAIL done_hold: got done=%b perst_n=%h, want 1 f", done, perst_n);
    end
  endtask

  // Restart straight out of DONE.
  task automatic test_restart_from_done();
    do_start();
    checks++;
    if (perst_n !== 4'h0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_restart: got perst_n=%h done=%b busy=%b, want 0 0 1", perst_n, done, busy);
    end
    run_to(500);
    checks++;
    if (perst_n !== 4'h1) begin
      errors++;
      $display("FAIL restart_ch0: got perst_n=%h, want 1", perst_n);
    end
    run_to(560);
    link_up = 4'hF;
    step();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done: got done=%b, want 1", done);
    end
  endtask

  task automatic test_ignore_start();
    link_up = 4'h0;
    do_start();
    run_to(189);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (perst_n !== 4'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_start: got perst_n=%h busy=%b, want 0 1", perst_n, busy);
    end
    run_to(500);
    checks++;
    if (perst_n !== 4'h1) begin
      errors++;
      $display("FAIL ignore_ch0: got perst_n=%h, want 1", perst_n);
    end
  endtask

  // Continues the sequence left running by test_ignore_start.
  task automatic test_mid_reset();
    run_to(519);
    reset_n = 1'b0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    reset_n = 1'b1;
    checks++;
    if (perst_n !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got perst_n=%h busy=%b done=%b timeout=%b, want 0 0 0 0",
               perst_n, busy, done, timeout);
    end
    repeat (9) step();
    do_start();
    checks++;
    if (busy !== 1'b1 || perst_n !== 4'h0) begin
      errors++;
      $display("FAIL reset_restart: got busy=%b perst_n=%h, want 1 0", busy, perst_n);
    end
    run_to(500);
    checks++;
    if (perst_n !== 4'h1) begin
      errors++;
      $display("FAIL reset_restart_ch0: got perst_n=%h, want 1", perst_n);
    end
    run_to(560);
    link_up = 4'hF;
    step();
  endtask

`ifdef PERST_SEQ_WATCHDOG_EN
  task automatic test_timeout();
    link_up = 4'b1011;
    do_start();
    run_to(1547);
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_timeout: got timeout=%b busy=%b, want 0 1", timeout, busy);
    end
    run_to(1548);
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || ch_timeout !== 4'b0100 || perst_n !== 4'hF) begin
      errors++;
      $display("FAIL timeout: got timeout=%b busy=%b ch_to=%b perst_n=%h, want 1 0 0100 f",
               timeout, busy, ch_timeout, perst_n);
    end
    link_up = 4'hF;
    step();
    checks++;
    if (timeout !== 1'b1 || done !== 1'b0 || ch_timeout !== 4'b0100) begin
      errors++;
      $display("FAIL fail_hold: got timeout=%b done=%b ch_to=%b, want 1 0 0100",
               timeout, done, ch_timeout);
    end
  endtask

  // All-ones on the final watchdog edge must win.
  task automatic test_timeout_edge();
    link_up = 4'h0;
    do_start();
    run_to(1547);
    link_up = 4'hF;
    step();
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || ch_timeout !== 4'h0) begin
      errors++;
      $display("FAIL last_edge_win: got done=%b timeout=%b ch_to=%h, want 1 0 0",
               done, timeout, ch_timeout);
    end
  endtask
`else
  task automatic test_no_watchdog();
    bit bad;
    link_up = 4'h0;
    bad = 1'b0;
    do_start();
    run_to(548);
    repeat (3000) begin
      step();
      if (timeout !== 1'b0 || ch_timeout !== 4'h0 || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_watchdog: got timeout=%b ch_to=%h busy=%b, want 0 0 1",
               timeout, ch_timeout, busy);
    end
    link_up = 4'hF;
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_wd_done: got done=%b busy=%b, want 1 0", done, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_restart_from_done();
    test_ignore_start();
    test_mid_reset();
`ifdef PERST_SEQ_WATCHDOG_EN
    test_timeout();
    test_timeout_edge();
`else
    test_no_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
